led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl.sv | 119 +++++++++++
 tb/tb_led_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// Four-LED pattern controller: shift-left, shift-right, ping-pong and blink modes,
// stepped by a divided base tick, with mode/speed/pause keys and active-low LED drive.
module led_mode_ctrl #(
    parameter logic [29:0] TICK_MAX = 30'd24_999_999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_speed,
    input  logic       key_pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       step_strobe
);

    localparam logic [1:0] MODE_SHIFT_L = 2'd0;
    localparam logic [1:0] MODE_SHIFT_R = 2'd1;
    localparam logic [1:0] MODE_PING    = 2'd2;
    localparam logic [1:0] MODE_BLINK   = 2'd3;

    logic [29:0] tick_cnt;
    logic [2:0]  div;
    logic [1:0]  speed;
    logic [1:0]  pos;
    logic        dir_up;
    logic        phase;
    logic        paused;

    logic        tick;
    logic        step;
    logic        fire;
    logic [2:0]  div_last;
    logic [1:0]  pos_next;
    logic        dir_next;
    logic        phase_next;
    logic [3:0]  pattern;

    assign tick = (tick_cnt == TICK_MAX);
    assign step = tick && !paused && (div == div_last);
    // A mode change in the same cycle swallows the step.
    assign fire = step && !key_mode;

    always_comb begin
        div_last = 3'd0;
        case (speed)
            2'd0:    div_last = 3'd0;
            2'd1:    div_last = 3'd1;
            2'd2:    div_last = 3'd3;
            default: div_last = 3'd7;
        endcase
    end

    always_comb begin
        pos_next   = pos;
        dir_next   = dir_up;
        phase_next = phase;
        case (mode)
            MODE_SHIFT_L: pos_next = pos + 2'd1;
            MODE_SHIFT_R: pos_next = pos - 2'd1;
            MODE_PING: begin
                // Direction flips on arrival at an end, giving 0,1,2,3,2,1,0,1,...
                if (dir_up) begin
                    pos_next = pos + 2'd1;
                    if (pos == 2'd2) dir_next = 1'b0;
                end else begin
                    pos_next = pos - 2'd1;
                    if (pos == 2'd1) dir_next = 1'b1;
                end
            end
            default: phase_next = ~phase;
        endcase
    end

    always_comb begin
        pattern = 4'b1111;
        if (mode == MODE_BLINK) pattern = phase ? 4'b0000 : 4'b1111;
        else                    pattern = ~(4'b0001 << pos);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt    <= 30'd0;
            div         <= 3'd0;
            speed       <= 2'd0;
            mode        <= MODE_SHIFT_L;
            pos         <= 2'd0;
            dir_up      <= 1'b1;
            phase       <= 1'b0;
            paused      <= 1'b0;
            step_strobe <= 1'b0;
            led         <= 4'b1111;
        end else begin
            if (key_mode) begin
                mode     <= mode + 2'd1;
                pos      <= 2'd0;
                dir_up   <= 1'b1;
                phase    <= 1'b0;
                tick_cnt <= 30'd0;
                div      <= 3'd0;
            end else if (!paused) begin
                tick_cnt <= tick ? 30'd0 : tick_cnt + 30'd1;
                if (tick) div <= step ? 3'd0 : div + 3'd1;
                if (fire) begin
                    pos    <= pos_next;
                    dir_up <= dir_next;
                    phase  <= phase_next;
                end
            end
            if (key_speed) begin
                speed <= speed + 2'd1;
                div   <= 3'd0;
            end
            if (key_pause) paused <= ~paused;
            step_strobe <= fire;
            led         <= pattern;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with TICK_MAX = 3 (one base tick every 4 clocks).
module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_speed = 1'b0;
    logic       key_pause = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic       step_strobe;

    int checks = 0;
    int errors = 0;

    led_mode_ctrl #(.TICK_MAX(30'd3)) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_speed(key_speed),
        .key_pause(key_pause), .led(led), .mode(mode), .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    // Called at a negedge: keys high for one rising edge, then one idle cycle.
    // keys = {pause, speed, mode}
    task automatic pulse(input logic [2:0] keys);
        key_mode  = keys[0];
        key_speed = keys[1];
        key_pause = keys[2];
        @(negedge clk);
        key_mode  = 1'b0;
        key_speed = 1'b0;
        key_pause = 1'b0;
        @(negedge clk);
    endtask

    // Waits for the next strobe (bounded), then samples one negedge later.
    // When entered one negedge after the previous strobe, interval is the
    // strobe-to-strobe distance in clocks; a timeout yields interval 102.
    task automatic next_step(output int interval, output logic [3:0] led_after,
                             output logic strobe_after);
        int n;
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (step_strobe === 1'b1) break;
        end
        interval = n + 1;
        @(negedge clk);
        led_after    = led;
        strobe_after = step_strobe;
    endtask

    task automatic test_reset;
        logic [3:0] exp_led [0:3];
        int iv; logic [3:0] la; logic sa;
        exp_led = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL reset_led: got %b expected 1111", led); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", step_strobe); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (led !== 4'b1110) begin errors++; $display("FAIL first_led: got %b expected 1110", led); end
        for (int i = 0; i < 4; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_led[i]) begin errors++; $display("FAIL shl_led step %0d: got %b expected %b", i, la, exp_led[i]); end
            checks++; if (iv !== 4) begin errors++; $display("FAIL shl_interval step %0d: got %0d expected 4", i, iv); end
            checks++; if (sa !== 1'b0) begin errors++; $display("FAIL strobe_width step %0d: got %b expected 0", i, sa); end
        end
    endtask

    task automatic test_mode;
        logic [3:0] exp_led [0:2];
        logic [1:0] exp_mode [0:2];
        int iv; logic [3:0] la; logic sa;
        exp_led  = '{4'b0111, 4'b1011, 4'b1101};
        exp_mode = '{2'd2, 2'd3, 2'd0};
        pulse(3'b001);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL mode_adv: got %0d expected 1", mode); end
        checks++; if (led !== 4'b1110) begin errors++; $display("FAIL shr_entry_led: got %b expected 1110", led); end
        for (int i = 0; i < 3; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_led[i]) begin errors++; $display("FAIL shr_led step %0d: got %b expected %b", i, la, exp_led[i]); end
            if (i > 0) begin
                checks++; if (iv !== 4) begin errors++; $display("FAIL shr_interval step %0d: got %0d expected 4", i, iv); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            pulse(3'b001);
            checks++; if (mode !== exp_mode[i]) begin errors++; $display("FAIL mode_wrap %0d: got %0d expected %0d", i, mode, exp_mode[i]); end
        end
    endtask

    task automatic test_ping;
        logic [3:0] exp_led [0:7];
        int iv; logic [3:0] la; logic sa;
        exp_led = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};
        pulse(3'b001);
        pulse(3'b001);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL ping_mode: got %0d expected 2", mode); end
        for (int i = 0; i < 8; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_led[i]) begin errors++; $display("FAIL ping_led step %0d: got %b expected %b", i, la, exp_led[i]); end
            if (i > 0) begin
                checks++; if (iv !== 4) begin errors++; $display("FAIL ping_interval step %0d: got %0d expected 4", i, iv); end
            end
        end
    endtask

    task automatic test_blink;
        logic [3:0] exp_led [0:3];
        int iv; logic [3:0] la; logic sa;
        exp_led = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
        pulse(3'b001);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL blink_mode: got %0d expected 3", mode); end
        for (int i = 0; i < 4; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_led[i]) begin errors++; $display("FAIL blink_led step %0d: got %b expected %b", i, la, exp_led[i]); end
        end
        pulse(3'b001);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL blink_exit_mode: got %0d expected 0", mode); end
    endtask

    task automatic test_speed;
        logic [3:0] exp_slow [0:2];
        logic [3:0] exp_fast [0:1];
        int iv; logic [3:0] la; logic sa;
        exp_slow = '{4'b1101, 4'b1011, 4'b0111};
        exp_fast = '{4'b1110, 4'b1101};
        pulse(3'b010);
        pulse(3'b010);
        for (int i = 0; i < 3; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_slow[i]) begin errors++; $display("FAIL speed2_led step %0d: got %b expected %b", i, la, exp_slow[i]); end
            if (i > 0) begin
                checks++; if (iv !== 16) begin errors++; $display("FAIL speed2_interval step %0d: got %0d expected 16", i, iv); end
            end
        end
        pulse(3'b010);
        pulse(3'b010);
        for (int i = 0; i < 2; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_fast[i]) begin errors++; $display("FAIL speed0_led step %0d: got %b expected %b", i, la, exp_fast[i]); end
            if (i > 0) begin
                checks++; if (iv !== 4) begin errors++; $display("FAIL speed0_interval step %0d: got %0d expected 4", i, iv); end
            end
        end
    endtask

    // Entered one clock after the step to pos 1; the pause key lands on the step to pos 2.
    task automatic test_pause;
        int iv; logic [3:0] la; logic sa;
        int bad = 0;
        repeat (2) @(negedge clk);
        key_pause = 1'b1;
        @(negedge clk);
        key_pause = 1'b0;
        checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL pause_edge_step: got %b expected 1", step_strobe); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (led !== 4'b1011 || step_strobe !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL pause_hold: %0d bad cycles expected 0 (led %b)", bad, led); end
        pulse(3'b100);
        next_step(iv, la, sa);
        checks++; if (iv !== 4) begin errors++; $display("FAIL resume_interval: got %0d expected 4", iv); end
        checks++; if (la !== 4'b0111) begin errors++; $display("FAIL resume_led: got %b expected 0111", la); end
    endtask

    task automatic test_paused_keys;
        int iv; logic [3:0] la; logic sa;
        int bad = 0;
        pulse(3'b100);
        pulse(3'b001);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL paused_mode: got %0d expected 1", mode); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (led !== 4'b1110 || step_strobe !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL paused_stays: %0d bad cycles expected 0 (led %b)", bad, led); end
        pulse(3'b100);
        next_step(iv, la, sa);
        checks++; if (la !== 4'b0111) begin errors++; $display("FAIL unpaused_shr_led: got %b expected 0111", la); end
    endtask

    // Entered one clock after a SHIFT_R step; key_mode lands on the next step edge.
    task automatic test_mode_priority;
        int iv; logic [3:0] la; logic sa;
        repeat (2) @(negedge clk);
        key_mode = 1'b1;
        @(negedge clk);
        key_mode = 1'b0;
        checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL prio_strobe: got %b expected 0", step_strobe); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL prio_mode: got %0d expected 2", mode); end
        @(negedge clk);
        checks++; if (led !== 4'b1110) begin errors++; $display("FAIL prio_led: got %b expected 1110", led); end
        next_step(iv, la, sa);
        checks++; if (la !== 4'b1101) begin errors++; $display("FAIL prio_next_led: got %b expected 1101", la); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_led [0:1];
        int iv; logic [3:0] la; logic sa;
        exp_led = '{4'b1101, 4'b1011};
        pulse(3'b010);
        pulse(3'b100);
        #2 rst = 1'b0;
        #1;
        checks++; if (led !== 4'b1111) begin errors++; $display("FAIL async_led: got %b expected 1111", led); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL async_mode: got %0d expected 0", mode); end
        checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL async_strobe: got %b expected 0", step_strobe); end
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (led !== 4'b1110) begin errors++; $display("FAIL rerelease_led: got %b expected 1110", led); end
        for (int i = 0; i < 2; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_led[i]) begin errors++; $display("FAIL rerun_led step %0d: got %b expected %b", i, la, exp_led[i]); end
            checks++; if (iv !== 4) begin errors++; $display("FAIL rerun_interval step %0d: got %0d expected 4", i, iv); end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp_led [0:1];
        int iv; logic [3:0] la; logic sa;
        int bad = 0;
        exp_led = '{4'b0111, 4'b1011};
        pulse(3'b111);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL simul_mode: got %0d expected 1", mode); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (led !== 4'b1110 || step_strobe !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL simul_paused: %0d bad cycles expected 0 (led %b)", bad, led); end
        pulse(3'b100);
        for (int i = 0; i < 2; i++) begin
            next_step(iv, la, sa);
            checks++; if (la !== exp_led[i]) begin errors++; $display("FAIL simul_led step %0d: got %b expected %b", i, la, exp_led[i]); end
            if (i > 0) begin
                checks++; if (iv !== 8) begin errors++; $display("FAIL simul_interval step %0d: got %0d expected 8", i, iv); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode();
        test_ping();
        test_blink();
        test_speed();
        test_pause();
        test_paused_keys();
        test_mode_priority();
        test_reset_mid();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
